// File: rtl/single_clk_ram_sweep_clr.sv
// Single-clock simple-dual-port RAM with registered read and a one-word-per-cycle
// sweep clear that runs after reset and on clr_req, so the array stays inferable as block RAM.
module single_clk_ram_sweep_clr #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 7,
    parameter int RDW_NEW_DATA = 0
) (
    input  logic                  clk,
    input  logic                  async_clear_n,
    input  logic                  clr_req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  cnt_last;
    logic                  acc_wr, acc_rd, rdw_hit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign cnt_last = (cnt == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) state <= CLEAR;
        else                state <= state_nxt;
    end

    // clr_req is only looked at in IDLE, so a request during a sweep never restarts it
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt_last) state_nxt = IDLE;
            IDLE:    if (clr_req)  state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state == CLEAR);
        acc_wr = (state == IDLE) && we;
        acc_rd = (state == IDLE) && rd_en;
        mem_we = busy | acc_wr;
        mem_wa = busy ? cnt : write_addr;
        mem_wd = busy ? '0  : data;
    end

    // Counter self-wraps to 0 on the last sweep word and is held at 0 outside CLEAR
    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n)     cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + 1'b1;
        else                    cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign rdw_hit = (RDW_NEW_DATA != 0) && acc_wr && (write_addr == read_addr);

    // Non-blocking read of mem yields the pre-write word; the bypass supplies new-data mode
    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= acc_rd;
            if (acc_rd) q <= rdw_hit ? data : mem[read_addr];
        end
    end

endmodule

// File: tb/tb_single_clk_ram_sweep_clr.sv
// Bench for single_clk_ram_sweep_clr: two instances (old-data and new-data read-during-write)
// share one stimulus stream; a reference memory feeds a read scoreboard, plus a vector table.
module tb_single_clk_ram_sweep_clr;

    localparam int DW    = 4;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          async_clear_n;
    logic          clr_req, we, rd_en;
    logic [AW-1:0] write_addr, read_addr;
    logic [DW-1:0] data;
    logic [DW-1:0] q0, q1;
    logic          qv0, qv1, busy0, busy1;

    always #5 clk = ~clk;

    single_clk_ram_sweep_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW_DATA(0)) u_old (
        .clk(clk), .async_clear_n(async_clear_n), .clr_req(clr_req),
        .we(we), .write_addr(write_addr), .data(data),
        .rd_en(rd_en), .read_addr(read_addr),
        .q(q0), .q_valid(qv0), .busy(busy0)
    );

    single_clk_ram_sweep_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW_DATA(1)) u_new (
        .clk(clk), .async_clear_n(async_clear_n), .clr_req(clr_req),
        .we(we), .write_addr(write_addr), .data(data),
        .rd_en(rd_en), .read_addr(read_addr),
        .q(q1), .q_valid(qv1), .busy(busy1)
    );

    typedef struct {
        logic [DW-1:0] q_old;
        logic [DW-1:0] q_new;
    } exp_t;

    typedef struct {
        logic          w;
        logic [AW-1:0] wa;
        logic [DW-1:0] d;
        logic          r;
        logic [AW-1:0] ra;
        logic          exp_qv;
        logic [DW-1:0] exp_q_old;
        logic [DW-1:0] exp_q_new;
    } vec_t;

    int            n_chk  = 0;
    int            n_fail = 0;
    exp_t          sb[$];
    logic [DW-1:0] mdl [DEPTH];
    logic          exp_busy;
    int            sweep_left;
    logic [DW-1:0] exp_q_old, exp_q_new;
    vec_t          vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model the edge, sample 1ns after posedge, return at negedge
    task automatic do_cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                            input logic r, input logic [AW-1:0] ra, input logic c);
        logic acc;
        exp_t e;
        logic exp_qv;
        we = w; write_addr = wa; data = d; rd_en = r; read_addr = ra; clr_req = c;
        acc = !exp_busy;
        if (acc && r) begin
            e.q_old = mdl[ra];
            e.q_new = (w && wa == ra) ? d : mdl[ra];
            sb.push_back(e);
        end
        if (acc && w) mdl[wa] = d;
        @(posedge clk);
        #1;
        if (acc && c) begin
            exp_busy   = 1'b1;
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        end else if (exp_busy) begin
            sweep_left--;
            if (sweep_left == 0) exp_busy = 1'b0;
        end
        exp_qv = 1'b0;
        if (acc && r && sb.size() > 0) begin
            e = sb.pop_front();
            exp_q_old = e.q_old;
            exp_q_new = e.q_new;
            exp_qv = 1'b1;
        end
        chk("busy_old", 32'(busy0), 32'(exp_busy));
        chk("busy_new", 32'(busy1), 32'(exp_busy));
        chk("q_valid_old", 32'(qv0), 32'(exp_qv));
        chk("q_valid_new", 32'(qv1), 32'(exp_qv));
        chk("q_old", 32'(q0), 32'(exp_q_old));
        chk("q_new", 32'(q1), 32'(exp_q_new));
        @(negedge clk);
        we = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Called at a negedge: hold reset low for one clock and check outputs react at once
    task automatic reset_pulse();
        async_clear_n = 1'b0;
        #1;
        chk("rst_q_old", 32'(q0), 32'h0);
        chk("rst_q_new", 32'(q1), 32'h0);
        chk("rst_qv", 32'(qv0 | qv1), 32'h0);
        chk("rst_busy", 32'(busy0 & busy1), 32'h1);
        sb.delete();
        exp_q_old  = '0;
        exp_q_new  = '0;
        exp_busy   = 1'b1;
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        @(negedge clk);
        async_clear_n = 1'b1;
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < DEPTH; a++) do_cycle(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
    endtask

    initial begin
        async_clear_n = 1'b0;
        clr_req = 1'b0; we = 1'b0; rd_en = 1'b0;
        write_addr = '0; read_addr = '0; data = '0;
        exp_busy = 1'b1; sweep_left = DEPTH;
        exp_q_old = '0; exp_q_new = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        vecs[0] = '{1'b1, 7'd5,  4'hA, 1'b0, 7'd0,  1'b0, 4'h0, 4'h0};
        vecs[1] = '{1'b0, 7'd0,  4'h0, 1'b1, 7'd5,  1'b1, 4'hA, 4'hA};
        vecs[2] = '{1'b0, 7'd0,  4'h0, 1'b0, 7'd0,  1'b0, 4'hA, 4'hA};
        vecs[3] = '{1'b1, 7'd9,  4'hC, 1'b0, 7'd0,  1'b0, 4'hA, 4'hA};
        vecs[4] = '{1'b1, 7'd9,  4'h3, 1'b1, 7'd9,  1'b1, 4'hC, 4'h3};
        vecs[5] = '{1'b0, 7'd0,  4'h0, 1'b1, 7'd9,  1'b1, 4'h3, 4'h3};
        vecs[6] = '{1'b1, 7'd10, 4'h7, 1'b1, 7'd9,  1'b1, 4'h3, 4'h3};
        vecs[7] = '{1'b0, 7'd0,  4'h0, 1'b1, 7'd10, 1'b1, 4'h7, 4'h7};
        vecs[8] = '{1'b1, 7'd11, 4'hF, 1'b1, 7'd10, 1'b1, 4'h7, 4'h7};
        vecs[9] = '{1'b0, 7'd0,  4'h0, 1'b1, 7'd11, 1'b1, 4'hF, 4'hF};

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy0 & busy1), 32'h1);
        chk("reset_qv", 32'(qv0 | qv1), 32'h0);
        chk("reset_q", 32'({q0, q1}), 32'h0);
        async_clear_n = 1'b1;

        // Power-on sweep: busy for exactly DEPTH cycles, then any address reads 0
        for (int i = 0; i < DEPTH; i++) idle_cycle();
        do_cycle(1'b0, '0, '0, 1'b1, 7'd77, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_cycle(vecs[i].w, vecs[i].wa, vecs[i].d, vecs[i].r, vecs[i].ra, 1'b0);
            chk($sformatf("vec%0d_qv", i), 32'(qv0 & qv1), 32'(vecs[i].exp_qv));
            chk($sformatf("vec%0d_q_old", i), 32'(q0), 32'(vecs[i].exp_q_old));
            chk($sformatf("vec%0d_q_new", i), 32'(q1), 32'(vecs[i].exp_q_new));
        end

        // Fill with addr[3:0] while reading back the previous word each cycle
        for (int a = 0; a < DEPTH; a++)
            do_cycle(1'b1, AW'(a), DW'(a), a > 0, AW'(a - 1), 1'b0);
        do_cycle(1'b0, '0, '0, 1'b1, 7'd127, 1'b0);

        // Requested sweep; traffic and a second clr_req at sweep cycle 20 are ignored
        do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b1, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(1, 15)),
                     1'b1, AW'($urandom_range(0, DEPTH - 1)), i == 20);
        read_all_zero();

        // Dirty some words, start a sweep, then reset it at count 60
        for (int a = 0; a < 16; a++) do_cycle(1'b1, AW'(a * 8), 4'h5, 1'b0, '0, 1'b0);
        do_cycle(1'b0, '0, '0, 1'b1, 7'd8, 1'b0);
        do_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 60; i++) idle_cycle();
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) idle_cycle();
        read_all_zero();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/single_clk_ram_sweep_clr.md
Name: single_clk_ram_sweep_clr

Overview:
- Parametrised single-clock simple-dual-port RAM: one write port, one read port, registered read data with a valid flag.
- Memory clear is a sequential sweep FSM, one word per cycle, so the array still infers as block RAM instead of flops.
- The sweep runs automatically after reset release and on request via clr_req.
- Used as per-channel coefficient/state storage in the divider datapath, with selectable read-during-write behaviour.

Parameters:
- DATA_WIDTH, 4, width of each word in bits.
- ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH.
- RDW_NEW_DATA, 0, same-address read-during-write: 0 returns old data, 1 returns the data being written.

Ports:
- clk  input  1  single system clock, rising edge.
- async_clear_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- clr_req  input  1  single-cycle pulse; starts a full memory sweep-clear.
- we  input  1  write enable.
- write_addr  input  ADDR_WIDTH  write address.
- data  input  DATA_WIDTH  write data.
- rd_en  input  1  read enable.
- read_addr  input  ADDR_WIDTH  read address.
- q  output  DATA_WIDTH  registered read data.
- q_valid  output  1  q holds the result of a read accepted on the previous cycle.
- busy  output  1  sweep in progress; port accesses are ignored.

Behaviour:
- Reset is one clock, asynchronous, active-low. While async_clear_n=0: q=0, q_valid=0, busy=1, FSM=CLEAR, sweep counter=0. The array itself is not reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - On the cycle cnt==2**ADDR_WIDTH-1, writes the last word and moves to IDLE with cnt=0.
  - A sweep takes exactly 2**ADDR_WIDTH cycles. busy=1 throughout.
- IDLE: busy=0. clr_req=1 moves to CLEAR next cycle with cnt=0. clr_req in CLEAR is ignored (no restart).
- Reset asserted mid-sweep aborts it. After release the sweep restarts from address 0 and runs the full length.
- Write: in IDLE with we=1, mem[write_addr] <= data at that edge.
- Read: in IDLE with rd_en=1, on the next cycle q=mem[read_addr] and q_valid=1. Latency is 1 cycle.
- If no read is accepted, q_valid=0 next cycle and q holds its previous value.
- During CLEAR, including the cycle clr_req is sampled in IDLE: we and rd_en are still honoured on that sampling cycle. From the first CLEAR cycle they are dropped with no side effects, and q_valid=0.
- Read-during-write, same address, same cycle:
  - RDW_NEW_DATA=0: q = pre-write contents.
  - RDW_NEW_DATA=1: q = data.
  - Different addresses never interact.
- Back-to-back reads and writes are accepted every cycle; there are no stalls in IDLE.
- Address wrap: addresses are full ADDR_WIDTH; no out-of-range case exists. The sweep counter wraps to 0 on exit.
- busy falls in the same cycle FSM enters IDLE. The first accepted access is on the cycle busy is first observed 0.

Test Plan:
- Reset release with ADDR_WIDTH=7 -> busy=1 for exactly 128 cycles, then 0. A read of any address afterwards returns 0 with q_valid=1 one cycle later.
- Write 4'hA to addr 5, then rd_en addr 5 next cycle -> q=4'hA, q_valid=1 one cycle after rd_en. Idle cycle -> q_valid=0, q stays 4'hA.
- Same-cycle we=1 data=4'h3 and rd_en=1, both at addr 9 (previously 4'hC):
  - RDW_NEW_DATA=0 -> q=4'hC.
  - RDW_NEW_DATA=1 -> q=4'h3.
- Fill addr 0..127 with addr[3:0], then pulse clr_req -> busy=1 for 128 cycles. we/rd_en issued during busy have no effect and q_valid=0. Afterwards all reads return 0.
- Pulse async_clear_n low for 1 cycle at sweep count 60 -> outputs reset immediately. After release busy lasts a full 128 cycles and all addresses read 0.
- clr_req pulsed again at sweep cycle 20 -> ignored; busy still drops 128 cycles after the original sweep start.
